cpu_sequencer: RTL and testbench

Multicycle state sequencer for the MIPS core. It generates the state_t value (FETCH/EXEC1/EXEC2) consumed by the control decoder, and stalls on bus waitrequest and on a busy multi-cycle unit. It detects the end-of-program condition (jump to address 0 plus its delay slot), parks the core in HALT, and keeps performance counters.

---
 rtl/cpu_sequencer.sv | 127 ++++++++++++
 tb/tb_cpu_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle FETCH/EXEC1/EXEC2 sequencer with halt detection and perf counters
// Optional bus-stall timeout fault: define SEQ_STALL_TIMEOUT_EN.
module cpu_sequencer #(
    parameter int CNT_W         = 32,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             waitrequest_i,
    input  logic             mem_req_i,
    input  logic             busy_i,
    input  logic             jump_zero_i,
    output logic [2:0]       state_o,
    output logic             active_o,
    output logic             delay_slot_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic             error_o
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC1 = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_HALT  = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic             delay_slot_q, delay_slot_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             error_q, error_d;
    logic             stall;
    logic             active;

    assign stall  = mem_req_i & waitrequest_i;
    assign active = (state_q != ST_HALT);

`ifdef SEQ_STALL_TIMEOUT_EN
    localparam int TO_W = $clog2(STALL_TIMEOUT + 1);
    logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (STALL_TIMEOUT > 0);
`endif

    always_comb begin
        state_d      = state_q;
        delay_slot_d = delay_slot_q;
        cycle_d      = cycle_q;
        instr_d      = instr_q;
        error_d      = error_q;

        if (active) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        case (state_q)
            ST_FETCH: if (!stall) state_d = ST_EXEC1;
            ST_EXEC1: if (!stall) state_d = ST_EXEC2;
            ST_EXEC2: begin
                if (!stall && !busy_i) begin
                    instr_d = instr_q + CNT_W'(1);
                    // A jump to 0 still runs its delay slot before parking.
                    if (delay_slot_q) begin
                        state_d      = ST_HALT;
                        delay_slot_d = 1'b0;
                    end else begin
                        state_d      = ST_FETCH;
                        delay_slot_d = jump_zero_i;
                    end
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase

`ifdef SEQ_STALL_TIMEOUT_EN
        stall_cnt_d = (active && stall) ? stall_cnt_q + TO_W'(1) : '0;
        // The STALL_TIMEOUT-th consecutive stall cycle parks the core with a fault.
        if (active && stall && (stall_cnt_q == TO_W'(STALL_TIMEOUT - 1))) begin
            state_d      = ST_HALT;
            error_d      = 1'b1;
            delay_slot_d = 1'b0;
            instr_d      = instr_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_FETCH;
            delay_slot_q <= 1'b0;
            cycle_q      <= '0;
            instr_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_slot_q <= delay_slot_d;
            cycle_q      <= cycle_d;
            instr_q      <= instr_d;
            error_q      <= error_d;
        end
    end

`ifdef SEQ_STALL_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign error_o = error_q;
`else
    logic unused_error;
    assign unused_error = error_q;
    assign error_o      = 1'b0;
`endif

    assign state_o       = state_q;
    assign active_o      = active;
    assign delay_slot_o  = delay_slot_q;
    assign cycle_count_o = cycle_q;
    assign instr_count_o = instr_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed-vector bench for cpu_sequencer
module tb_cpu_sequencer;

    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] EXEC1 = 3'd1;
    localparam logic [2:0] EXEC2 = 3'd2;
    localparam logic [2:0] HALT  = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        waitrequest, mem_req, busy, jump_zero;
    logic [2:0]  state;
    logic        active, delay_slot, error;
    logic [31:0] cycle_count, instr_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(32), .STALL_TIMEOUT(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .waitrequest_i (waitrequest),
        .mem_req_i     (mem_req),
        .busy_i        (busy),
        .jump_zero_i   (jump_zero),
        .state_o       (state),
        .active_o      (active),
        .delay_slot_o  (delay_slot),
        .cycle_count_o (cycle_count),
        .instr_count_o (instr_count),
        .error_o       (error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic act,
                             input logic ds, input int cyc, input int ins, input logic err);
        check({tag, ".state"}, 64'(state), 64'(st));
        check({tag, ".active"}, 64'(active), 64'(act));
        check({tag, ".delay"}, 64'(delay_slot), 64'(ds));
        check({tag, ".cycles"}, 64'(cycle_count), 64'(cyc));
        check({tag, ".instrs"}, 64'(instr_count), 64'(ins));
        check({tag, ".error"}, 64'(error), 64'(err));
    endtask

    logic [2:0] seq [3];

    initial begin
        seq[0] = FETCH; seq[1] = EXEC1; seq[2] = EXEC2;
        rst_n = 1'b0; waitrequest = 1'b0; mem_req = 1'b0; busy = 1'b0; jump_zero = 1'b0;
        #12;
        check_all("reset", FETCH, 1'b1, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;

        // Four back-to-back instructions, memory access in FETCH only
        for (int i = 0; i < 12; i++) begin
            mem_req = (i % 3 == 0);
            check($sformatf("seq%0d", i), 64'(state), 64'(seq[i % 3]));
            tick(1);
        end
        mem_req = 1'b0;
        check_all("four_instr", FETCH, 1'b1, 1'b0, 12, 4, 1'b0);

        // Five waitrequest cycles in FETCH
        mem_req = 1'b1; waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fetch_hold%0d", i), 64'(state), 64'(FETCH));
            tick(1);
        end
        waitrequest = 1'b0;
        check_all("fetch_stalled", FETCH, 1'b1, 1'b0, 17, 4, 1'b0);
        tick(1);
        mem_req = 1'b0;
        check("after_stall_exec1", 64'(state), 64'(EXEC1));
        tick(2);
        check_all("stall_instr", FETCH, 1'b1, 1'b0, 20, 5, 1'b0);

        // busy holds EXEC2; waitrequest without mem_req is ignored
        waitrequest = 1'b1;
        tick(2);
        check("busy_enter", 64'(state), 64'(EXEC2));
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy_hold%0d", i), 64'(state), 64'(EXEC2));
            tick(1);
        end
        busy = 1'b0;
        check("busy_released", 64'(state), 64'(EXEC2));
        tick(1);
        check_all("busy_instr", FETCH, 1'b1, 1'b0, 26, 6, 1'b0);

        // Bus stall alone holds EXEC2
        tick(2);
        mem_req = 1'b1;
        tick(1);
        check("exec2_wait_hold", 64'(state), 64'(EXEC2));
        mem_req = 1'b0;
        tick(1);
        check_all("exec2_wait_instr", FETCH, 1'b1, 1'b0, 30, 7, 1'b0);
        waitrequest = 1'b0;

        // Jump to zero on instruction 8, delay slot is instruction 9
        tick(2);
        jump_zero = 1'b1;
        tick(1);
        jump_zero = 1'b0;
        check_all("delay_slot_fetch", FETCH, 1'b1, 1'b1, 33, 8, 1'b0);
        tick(2);
        check("delay_slot_exec2", 64'(delay_slot), 64'(1));
        jump_zero = 1'b1;
        tick(1);
        check_all("halted", HALT, 1'b0, 1'b0, 36, 9, 1'b0);
        mem_req = 1'b1; waitrequest = 1'b1; busy = 1'b1;
        tick(20);
        check_all("halt_frozen", HALT, 1'b0, 1'b0, 36, 9, 1'b0);
        mem_req = 1'b0; waitrequest = 1'b0; busy = 1'b0; jump_zero = 1'b0;

        // Asynchronous reset from HALT
        #2 rst_n = 1'b0;
        #1 check_all("reset_from_halt", FETCH, 1'b1, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;

        // Asynchronous reset while stalled in EXEC1
        tick(1);
        mem_req = 1'b1; waitrequest = 1'b1;
        tick(1);
        check_all("exec1_stalled", EXEC1, 1'b1, 1'b0, 2, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all("reset_mid_exec1", FETCH, 1'b1, 1'b0, 0, 0, 1'b0);
        mem_req = 1'b0; waitrequest = 1'b0;
        rst_n = 1'b1;

        // Seven stall cycles in EXEC1: below the timeout
        tick(1);
        mem_req = 1'b1; waitrequest = 1'b1;
        tick(7);
        check("stall7_exec1", 64'(state), 64'(EXEC1));
        mem_req = 1'b0; waitrequest = 1'b0;
        tick(2);
        check_all("stall7_done", FETCH, 1'b1, 1'b0, 10, 1, 1'b0);

`ifdef SEQ_STALL_TIMEOUT_EN
        tick(1);
        mem_req = 1'b1; waitrequest = 1'b1;
        tick(7);
        check_all("stall8_pre", EXEC1, 1'b1, 1'b0, 18, 1, 1'b0);
        tick(1);
        check_all("stall8_timeout", HALT, 1'b0, 1'b0, 19, 1, 1'b1);
        tick(5);
        check_all("timeout_sticky", HALT, 1'b0, 1'b0, 19, 1, 1'b1);
        mem_req = 1'b0; waitrequest = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all("timeout_reset", FETCH, 1'b1, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
`else
        tick(1);
        mem_req = 1'b1; waitrequest = 1'b1;
        tick(20);
        check_all("long_stall", EXEC1, 1'b1, 1'b0, 31, 1, 1'b0);
        mem_req = 1'b0; waitrequest = 1'b0;
        tick(2);
        check_all("long_stall_done", FETCH, 1'b1, 1'b0, 33, 2, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
